// File: rtl/pdm_sample_feeder.sv
// pdm_sample_feeder: buffers stream samples in a small FIFO and releases one
// sample per timer tick onto a registered output that feeds the PDM modulator.
//
// Handshake: a sample is pushed on any rising edge where s_axis_tvalid and
// s_axis_tready are both high. s_axis_tready is a registered flag meaning
// "FIFO not full". It never depends on s_axis_tvalid and is low while in reset.
module pdm_sample_feeder #(
  parameter int NBITS     = 11,
  parameter int FIFO_AW   = 2,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NBITS-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 enable,
  input  logic                 clear_underflow,
  output logic [NBITS-1:0]     dout,
  output logic                 underflow,
  output logic [FIFO_AW:0]     fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

  logic [NBITS-1:0]     mem [DEPTH];
  logic [FIFO_AW-1:0]   wptr;
  logic [FIFO_AW-1:0]   rptr;
  logic [FIFO_AW:0]     count;
  logic [FIFO_AW:0]     count_nxt;
  logic                 ready_q;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 tick;
  logic                 push;
  logic                 pop;

  // A pop needs data present before the edge, so a sample pushed on this
  // edge is never popped on the same edge.
  assign tick = enable && (cnt == '0);
  assign push = s_axis_tvalid && ready_q;
  assign pop  = tick && (count != '0);

  assign s_axis_tready = ready_q;
  assign fifo_count    = count;

  // Next occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Sample storage; contents are left stale on reset because the pointers
  // and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= s_axis_tdata;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count   <= count_nxt;
      ready_q <= (count_nxt != FULL);
    end
  end

  // Update timer: reloads from period while idle or on a tick, so a new
  // period only takes effect at the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= period;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Output sample register: changes only on a tick that finds data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (pop) begin
      dout <= mem[rptr];
    end
  end

  // Sticky underflow: an empty tick wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (tick && (count == '0)) begin
      underflow <= 1'b1;
    end else if (clear_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Testbench for pdm_sample_feeder: directed scenarios plus a randomized run,
// checked against a cycle-scheduled reference model of the feeder.
module tb_pdm_sample_feeder;

  localparam int NBITS     = 11;
  localparam int FIFO_AW   = 2;
  localparam int DIV_WIDTH = 16;
  localparam int DEPTH     = 1 << FIFO_AW;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NBITS-1:0]     s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [DIV_WIDTH-1:0] period = '0;
  logic                 enable = 1'b0;
  logic                 clear_underflow = 1'b0;
  logic [NBITS-1:0]     dout;
  logic                 underflow;
  logic [FIFO_AW:0]     fifo_count;

  always #5 clk = ~clk;

  pdm_sample_feeder #(.NBITS(NBITS), .FIFO_AW(FIFO_AW), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .period          (period),
    .enable          (enable),
    .clear_underflow (clear_underflow),
    .dout            (dout),
    .underflow       (underflow),
    .fifo_count      (fifo_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model / scoreboard ----------------
  // Ticks are scheduled in absolute edge numbers: each reload (enable low or
  // a tick) schedules the next tick period+1 edges later; after reset the
  // first enabled edge ticks at once.
  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] m_dout = '0;
  logic             m_uf = 1'b0;
  logic             m_ready = 1'b0;
  int               m_e = 0;
  int               m_nt = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_dout  = '0;
      m_uf    = 1'b0;
      m_ready = 1'b0;
      m_nt    = m_e + 1;
    end else begin
      bit m_tick;
      bit m_pop;
      bit m_push;
      m_e++;
      m_tick = enable && (m_e == m_nt);
      if (!enable || m_tick) m_nt = m_e + int'(period) + 1;
      m_pop  = m_tick && (exp_q.size() > 0);
      m_push = s_axis_tvalid && m_ready;
      if (m_tick && exp_q.size() == 0) m_uf = 1'b1;
      else if (clear_underflow) m_uf = 1'b0;
      if (m_pop) m_dout = exp_q.pop_front();
      if (m_push) exp_q.push_back(s_axis_tdata);
      m_ready = (exp_q.size() != DEPTH);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [NBITS-1:0] d);
    int waited = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    while (s_axis_tready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL push_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, waited);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    period = 16'd3;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (dout !== 11'h000) begin n_bad++; $display("FAIL reset_dout: got %h want 000", dout); end
    if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push_idle();
    push(11'h7FF);
    push(11'h001);
    push(11'h400);
    n_cmp += 4;
    if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL idle_count: got %0d want 3", fifo_count); end
    if (dout !== 11'h000) begin n_bad++; $display("FAIL idle_dout: got %h want 000", dout); end
    if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL idle_tready: got %b want 1", s_axis_tready); end
    if (underflow !== 1'b0) begin n_bad++; $display("FAIL idle_underflow: got %b want 0", underflow); end
  endtask

  // Ticks at 4, 8, 12 then an empty tick at 16, clear checks at 18 and 20.
  task automatic test_ticks_underflow();
    logic [NBITS-1:0] exp_d [3] = '{11'h7FF, 11'h001, 11'h400};
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_cmp++;
        if (dout !== 11'h000) begin n_bad++; $display("FAIL pre_tick_dout: got %h want 000", dout); end
      end
      if (k % 4 == 0 && k <= 12) begin
        n_cmp += 2;
        if (dout !== exp_d[k/4-1]) begin n_bad++; $display("FAIL tick_dout k=%0d: got %h want %h", k, dout, exp_d[k/4-1]); end
        if (fifo_count !== 3'(3 - k/4)) begin n_bad++; $display("FAIL tick_count k=%0d: got %0d want %0d", k, fifo_count, 3 - k/4); end
      end
      if (k == 15) begin
        n_cmp++;
        if (underflow !== 1'b0) begin n_bad++; $display("FAIL early_underflow: got %b want 0", underflow); end
      end
    end
    n_cmp += 2;
    if (underflow !== 1'b1) begin n_bad++; $display("FAIL empty_tick_underflow: got %b want 1", underflow); end
    if (dout !== 11'h400) begin n_bad++; $display("FAIL hold_dout: got %h want 400", dout); end
    @(negedge clk);                      // 17
    clear_underflow = 1'b1;
    @(negedge clk);                      // 18: non-tick clear
    clear_underflow = 1'b0;
    n_cmp++;
    if (underflow !== 1'b0) begin n_bad++; $display("FAIL clear_underflow: got %b want 0", underflow); end
    @(negedge clk);                      // 19
    clear_underflow = 1'b1;
    @(negedge clk);                      // 20: empty tick beats clear
    clear_underflow = 1'b0;
    n_cmp++;
    if (underflow !== 1'b1) begin n_bad++; $display("FAIL set_wins: got %b want 1", underflow); end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata = 11'($urandom);
      @(negedge clk);
    end
    n_cmp += 2;
    if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL full_tready: got %b want 0", s_axis_tready); end
    period = 16'd0;
    @(negedge clk);
    enable = 1'b1;
    s_axis_tdata = 11'($urandom);
    @(negedge clk);
    n_cmp += 3;
    if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL pop_frees_tready: got %b want 1", s_axis_tready); end
    if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL first_pop_count: got %0d want 3", fifo_count); end
    if (dout !== m_dout) begin n_bad++; $display("FAIL first_pop_dout: got %h want %h", dout, m_dout); end
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata = 11'($urandom);
      @(negedge clk);
      n_cmp += 2;
      if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL steady_count i=%0d: got %0d want 3", i, fifo_count); end
      if (dout !== m_dout) begin n_bad++; $display("FAIL steady_dout i=%0d: got %h want %h", i, dout, m_dout); end
    end
    s_axis_tvalid = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(11'h123);
    push(11'h2AA);
    push(11'h055);
    enable = 1'b1;                       // period is 0 and loaded: one tick
    @(negedge clk);
    enable = 1'b0;
    n_cmp += 2;
    if (dout !== 11'h123) begin n_bad++; $display("FAIL pre_reset_dout: got %h want 123", dout); end
    if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL pre_reset_count: got %0d want 2", fifo_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (dout !== 11'h000) begin n_bad++; $display("FAIL async_dout: got %h want 000", dout); end
    if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL async_count: got %0d want 0", fifo_count); end
    if (underflow !== 1'b0) begin n_bad++; $display("FAIL async_underflow: got %b want 0", underflow); end
    if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL async_tready: got %b want 0", s_axis_tready); end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (underflow !== 1'b1) begin n_bad++; $display("FAIL post_reset_underflow: got %b want 1", underflow); end
    enable = 1'b0;
  endtask

  // Ticks at 4 and 8 on the old period, then every 2 cycles.
  task automatic test_period_change();
    for (int i = 0; i < 4; i++) push(11'($urandom));
    period = 16'd3;
    @(negedge clk);
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int exp_c;
      @(negedge clk);
      exp_c = (k < 4) ? 4 : (k < 8) ? 3 : (k < 10) ? 2 : (k < 12) ? 1 : 0;
      n_cmp++;
      if (fifo_count !== 3'(exp_c)) begin n_bad++; $display("FAIL period_change_count k=%0d: got %0d want %0d", k, fifo_count, exp_c); end
      if (k == 5) period = 16'd1;
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_cmp += 4;
      if (dout !== m_dout) begin n_bad++; $display("FAIL rand_dout i=%0d: got %h want %h", i, dout, m_dout); end
      if (underflow !== m_uf) begin n_bad++; $display("FAIL rand_underflow i=%0d: got %b want %b", i, underflow, m_uf); end
      if (fifo_count !== 3'(exp_q.size())) begin n_bad++; $display("FAIL rand_count i=%0d: got %0d want %0d", i, fifo_count, exp_q.size()); end
      if (s_axis_tready !== m_ready) begin n_bad++; $display("FAIL rand_tready i=%0d: got %b want %b", i, s_axis_tready, m_ready); end
      s_axis_tvalid   = 1'($urandom_range(0, 1));
      s_axis_tdata    = 11'($urandom);
      enable          = ($urandom_range(0, 9) != 0);
      clear_underflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) period = 16'($urandom_range(0, 3));
    end
    s_axis_tvalid = 1'b0;
    enable = 1'b0;
    clear_underflow = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_push_idle();
    test_ticks_underflow();
    test_back_to_back();
    test_async_reset();
    test_period_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_sample_feeder.md
Name: pdm_sample_feeder

Overview:
- Upstream stage of the pulse-density modulator. Accepts NBITS-wide samples over a valid/ready stream into a small FIFO.
- Presents one sample at a time on a registered output that drives the modulator's din input.
- Advances to the next sample at a programmable update rate; holds the last value and flags underflow when starved.
- Lets software/DMA feed the PDM DAC at a sample rate far below clk.

Parameters:
- NBITS, 11, sample width; must match the downstream modulator.
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW entries.
- DIV_WIDTH, 16, width of the update-period register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NBITS  unsigned sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  FIFO can accept a sample.
- period  in  DIV_WIDTH  update interval minus one, in clk cycles.
- enable  in  1  run the update timer.
- clear_underflow  in  1  single-cycle clear of the sticky underflow flag.
- dout  out  NBITS  registered sample for the modulator din.
- underflow  out  1  sticky: a tick found the FIFO empty.
- fifo_count  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and fifo_count go to 0; timer counter loads 0.
  - dout = 0, underflow = 0, s_axis_tready = 0 while rst_n is low.
  - All state is cleared immediately, mid-operation included; in-flight FIFO data is discarded.
- Stream input:
  - s_axis_tready = (fifo_count != 2^FIFO_AW), a registered/pointer-derived flag, never dependent on tvalid.
  - A push occurs on an edge with tvalid & tready; the data is written at the write pointer and the pointer advances modulo depth.
- Timer:
  - Counter cnt, DIV_WIDTH bits.
  - enable low: cnt <= period; no ticks.
  - enable high and cnt == 0: tick this cycle; cnt <= period.
  - enable high and cnt != 0: cnt <= cnt - 1.
  - Ticks therefore occur every period+1 cycles. The first tick comes period+1 cycles after enable rises. period = 0 ticks every cycle.
  - A period change takes effect at the next reload, not mid-count.
- Tick action:
  - FIFO non-empty: pop the head; dout <= head on the same edge; read pointer advances.
  - FIFO empty: dout holds its value; underflow <= 1.
- Occupancy:
  - fifo_count increments on push-only, decrements on pop-only, and is unchanged on a simultaneous push and pop.
  - Simultaneous push and pop while empty is impossible: a pop requires a non-empty FIFO at the evaluating edge.
  - A sample pushed on edge N is poppable at the earliest on edge N+1.
  - Full-then-pop frees tready on the following cycle.
- underflow:
  - Set on an empty tick; cleared by clear_underflow.
  - If set and clear occur in the same cycle, set wins (underflow = 1).
- Disabling enable:
  - FIFO keeps accepting samples up to full; dout holds.
  - Re-enabling restarts the timer from period.
- dout changes only on tick edges or reset, so the modulator sees glitch-free, registered input.

Test Plan:
1. Reset, then push 0x7FF, 0x001, 0x400 with enable = 0 -> fifo_count = 3, dout = 0, tready = 1, underflow = 0.
2. period = 3, enable = 1, FIFO preloaded with 0x7FF, 0x001, 0x400 -> dout becomes 0x7FF, 0x001, 0x400 on ticks at cycles 4, 8, 12 after enable; fifo_count 2, 1, 0.
3. Continue scenario 2 with no pushes -> at cycle 16 underflow = 1 and dout stays 0x400. Asserting clear_underflow on a non-tick cycle -> underflow = 0. Asserting it on the next empty tick cycle -> underflow stays 1.
4. FIFO_AW = 2, tvalid held high, enable = 0 -> exactly 4 accepted, tready = 0, fifo_count = 4. Then period = 0, enable = 1 -> tready rises the cycle after the first pop; steady state is push/pop each cycle with fifo_count constant and dout following input order.
5. Mid-stream, with fifo_count = 2 and dout = 0x123, drop rst_n asynchronously between edges -> dout = 0, fifo_count = 0, underflow = 0, tready = 0 immediately. After release, the first tick with an empty FIFO sets underflow.
6. Change period from 3 to 1 between ticks -> the current interval completes at 4 cycles; subsequent ticks are every 2 cycles.
